// File: rtl/mgmt_sram_arbiter.sv
// mgmt_sram_arbiter: shares the single-port management SRAM (1-cycle read
// latency) between the CPU Wishbone slave port and the housekeeping
// read-only port. Round-robin arbitration, one access in flight at a time.
// Optional write protection of words below WPROT_TOP is enabled by defining
// MGMT_SRAM_ARB_WPROT_EN; without it wprot_viol is tied low.
module mgmt_sram_arbiter #(
  parameter int              AW        = 8,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   WPROT_TOP = 8'h10
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic              wb_ack_o,
  output logic [DW-1:0]     wb_dat_o,
  input  logic              hk_ro_req,
  input  logic [AW-1:0]     hk_ro_addr,
  output logic              hk_ro_ack,
  output logic [DW-1:0]     hk_ro_data,
  output logic              mem_ena,
  output logic [DW/8-1:0]   mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              wprot_viol
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  localparam logic RR_WB = 1'b0;
  localparam logic RR_HK = 1'b1;

`ifdef MGMT_SRAM_ARB_WPROT_EN
  localparam logic WPROT_ON = 1'b1;
`else
  localparam logic WPROT_ON = 1'b0;
`endif

  logic [1:0]    state;
  logic          rr_ptr;
  logic          gnt_hk;
  logic          gnt_wr;
  logic          wb_req;
  logic          pick_hk;
  logic          prot_hit;
  logic [AW-1:0] wb_word;
  logic          unused_adr;

  assign wb_req     = wb_cyc_i & wb_stb_i;
  assign wb_word    = wb_adr_i[AW+1:2];
  assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};
  assign prot_hit   = WPROT_ON & (wb_word < WPROT_TOP);

  // Arbitration: a lone requester wins; on contention the side rr_ptr does not name wins.
  always_comb begin
    pick_hk = hk_ro_req & (~wb_req | (rr_ptr == RR_WB));
  end

  // Access sequencer: IDLE grant -> ACCESS -> (CAPTURE on reads) -> ACK -> IDLE.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state      <= S_IDLE;
      rr_ptr     <= RR_WB;
      gnt_hk     <= 1'b0;
      gnt_wr     <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      hk_ro_ack  <= 1'b0;
      hk_ro_data <= '0;
      mem_ena    <= 1'b0;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef MGMT_SRAM_ARB_WPROT_EN
      wprot_viol <= 1'b0;
`endif
    end else begin
      wb_ack_o  <= 1'b0;
      hk_ro_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_req | hk_ro_req) begin
            state   <= S_ACCESS;
            mem_ena <= 1'b1;
            gnt_hk  <= pick_hk;
            rr_ptr  <= pick_hk ? RR_HK : RR_WB;
            if (pick_hk) begin
              mem_addr  <= hk_ro_addr;
              mem_wdata <= '0;
              mem_wen   <= '0;
              gnt_wr    <= 1'b0;
            end else begin
              mem_addr  <= wb_word;
              mem_wdata <= wb_dat_i;
              gnt_wr    <= wb_we_i;
              // A protected write still runs the full write timing, with no lanes enabled.
              mem_wen   <= (wb_we_i && !prot_hit) ? wb_sel_i : '0;
`ifdef MGMT_SRAM_ARB_WPROT_EN
              if (wb_we_i && prot_hit) wprot_viol <= 1'b1;
`endif
            end
          end
        end
        S_ACCESS: begin
          mem_ena <= 1'b0;
          mem_wen <= '0;
          if (gnt_wr) begin
            state    <= S_ACK;
            wb_ack_o <= 1'b1;
          end else begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          state <= S_ACK;
          if (gnt_hk) begin
            hk_ro_data <= mem_rdata;
            hk_ro_ack  <= 1'b1;
          end else begin
            wb_dat_o <= mem_rdata;
            wb_ack_o <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef MGMT_SRAM_ARB_WPROT_EN
  assign wprot_viol = 1'b0;
`endif

endmodule

// File: tb/tb_mgmt_sram_arbiter.sv
// tb_mgmt_sram_arbiter: directed literal checks followed by randomized
// traffic, compared every cycle against a transaction-level timeline model.
module tb_mgmt_sram_arbiter;

  logic        core_clk;
  logic        core_rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        hk_ro_req;
  logic [7:0]  hk_ro_addr;
  logic        hk_ro_ack;
  logic [31:0] hk_ro_data;
  logic        mem_ena;
  logic [3:0]  mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        wprot_viol;

  int checks = 0;
  int fails  = 0;

  mgmt_sram_arbiter #(.AW(8), .DW(32), .WPROT_TOP(8'h10)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .hk_ro_req(hk_ro_req), .hk_ro_addr(hk_ro_addr),
    .hk_ro_ack(hk_ro_ack), .hk_ro_data(hk_ro_data),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wprot_viol(wprot_viol)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

`ifdef MGMT_SRAM_ARB_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM emulation: 1-cycle read latency, byte-lane writes, garbage when idle.
  logic [31:0] ram [256];
  always @(posedge core_clk) begin
    if (mem_ena) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end else begin
      mem_rdata <= $urandom;
    end
  end

  // Timeline model: a grant opens a fixed-length slot; ack time and the next
  // free grant edge follow from the transaction kind alone.
  logic [31:0] shadow [256];
  bit          m_valid = 0;
  longint      cyc = 0, free_at = 0, ack_at = 0;
  bit          pend = 0, pend_hk = 0, pend_rd = 0, last_hk = 0;
  logic [31:0] pend_data;
  bit          m_ena, m_wb_ack, m_hk_ack, m_viol;
  logic [3:0]  m_wen;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_wb_dat, m_hk_dat;

  always @(posedge core_clk) begin
    bit wbq, pick;
    logic [7:0] idx;
    logic [3:0] lanes;
    cyc++;
    m_ena = 0; m_wen = 0; m_wb_ack = 0; m_hk_ack = 0;
    wbq = wb_cyc_i && wb_stb_i;
    if (core_rst) begin
      m_valid = 1; free_at = cyc + 1; pend = 0; last_hk = 0;
      m_wb_dat = 0; m_hk_dat = 0; m_viol = 0; m_addr = 0; m_wdata = 0;
    end else if (m_valid) begin
      if (pend && ack_at == cyc) begin
        pend = 0;
        if (pend_hk) begin m_hk_ack = 1; m_hk_dat = pend_data; end
        else begin m_wb_ack = 1; if (pend_rd) m_wb_dat = pend_data; end
      end
      if (cyc >= free_at && (wbq || hk_ro_req)) begin
        pick = hk_ro_req && (!wbq || !last_hk);
        last_hk = pick;
        m_ena = 1; pend = 1; pend_hk = pick;
        if (pick) begin
          m_addr = hk_ro_addr; pend_rd = 1; pend_data = shadow[hk_ro_addr];
          ack_at = cyc + 2; free_at = cyc + 4;
        end else begin
          idx = wb_adr_i[9:2]; m_addr = idx;
          if (wb_we_i) begin
            lanes = wb_sel_i;
            if (PROT && idx < 8'h10) begin lanes = 0; m_viol = 1; end
            m_wen = lanes; m_wdata = wb_dat_i; pend_rd = 0;
            for (int b = 0; b < 4; b++)
              if (lanes[b]) shadow[idx][8*b +: 8] = wb_dat_i[8*b +: 8];
            ack_at = cyc + 1; free_at = cyc + 3;
          end else begin
            pend_rd = 1; pend_data = shadow[idx];
            ack_at = cyc + 2; free_at = cyc + 4;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge core_clk) begin
    if (m_valid) begin
      chk("mem_ena", {31'b0, mem_ena}, {31'b0, m_ena});
      chk("mem_wen", {28'b0, mem_wen}, {28'b0, m_wen});
      if (m_ena) chk("mem_addr", {24'b0, mem_addr}, {24'b0, m_addr});
      if (m_wen != 0) chk("mem_wdata", mem_wdata, m_wdata);
      chk("wb_ack_o", {31'b0, wb_ack_o}, {31'b0, m_wb_ack});
      chk("hk_ro_ack", {31'b0, hk_ro_ack}, {31'b0, m_hk_ack});
      chk("wb_dat_o", wb_dat_o, m_wb_dat);
      chk("hk_ro_data", hk_ro_data, m_hk_dat);
      chk("wprot_viol", {31'b0, wprot_viol}, {31'b0, m_viol});
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output int lat, output int ena_cnt,
                         output logic [3:0] wen_seen, output logic [7:0] addr_seen,
                         output logic [31:0] rdat);
    @(negedge core_clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_sel_i = sel; wb_adr_i = adr; wb_dat_i = dat;
    lat = -1; ena_cnt = 0; wen_seen = 0; addr_seen = 0; rdat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge core_clk);
      if (mem_ena) begin ena_cnt++; wen_seen = mem_wen; addr_seen = mem_addr; end
      if (wb_ack_o) begin lat = k; rdat = wb_dat_o; break; end
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic hk_xfer(input logic [7:0] a, output int lat, output int ena_cnt,
                         output logic [3:0] wen_or, output logic [31:0] rdat);
    @(negedge core_clk);
    hk_ro_req = 1; hk_ro_addr = a;
    lat = -1; ena_cnt = 0; wen_or = 0; rdat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge core_clk);
      if (mem_ena) ena_cnt++;
      wen_or = wen_or | mem_wen;
      if (hk_ro_ack) begin lat = k; rdat = hk_ro_data; break; end
    end
    hk_ro_req = 0;
  endtask

  initial begin
    int lat, ena;
    logic [3:0] wen;
    logic [7:0] ad;
    logic [31:0] rd, v;
    int order [4];
    int nack, nena;
    bit wb_act, hk_act;

    for (int i = 0; i < 256; i++) begin v = $urandom; ram[i] = v; shadow[i] = v; end
    core_rst = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0;
    wb_adr_i = 0; wb_dat_i = 0; hk_ro_req = 0; hk_ro_addr = 0;
    repeat (3) @(negedge core_clk);
    chk("rst_mem_ena", {31'b0, mem_ena}, 32'd0);
    chk("rst_wb_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rst_wb_dat", wb_dat_o, 32'd0);
    chk("rst_hk_data", hk_ro_data, 32'd0);
    core_rst = 0;

    wb_xfer(1, 32'h40, 4'hF, 32'hDEADBEEF, lat, ena, wen, ad, rd);
    chk("wr_lat", lat, 2);
    chk("wr_ena_cycles", ena, 1);
    chk("wr_wen", {28'b0, wen}, 32'hF);
    chk("wr_addr", {24'b0, ad}, 32'h10);

    wb_xfer(0, 32'h40, 4'hF, 32'h0, lat, ena, wen, ad, rd);
    chk("rd_lat", lat, 3);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_wen", {28'b0, wen}, 32'h0);

    hk_xfer(8'h10, lat, ena, wen, rd);
    chk("hk_lat", lat, 3);
    chk("hk_data", rd, 32'hDEADBEEF);
    chk("hk_wen", {28'b0, wen}, 32'h0);
    chk("hk_ena_cycles", ena, 1);
    @(negedge core_clk);
    chk("hk_data_held", hk_ro_data, 32'hDEADBEEF);

    wb_xfer(1, 32'h44, 4'h0, 32'h12345678, lat, ena, wen, ad, rd);
    chk("sel0_lat", lat, 2);
    chk("sel0_wen", {28'b0, wen}, 32'h0);
    chk("sel0_ena_cycles", ena, 1);

    wb_xfer(1, 32'hFFFF_F048, 4'hF, 32'hA5A5_5A5A, lat, ena, wen, ad, rd);
    wb_xfer(0, 32'h0000_0048, 4'hF, 32'h0, lat, ena, wen, ad, rd);
    chk("alias_rd", rd, 32'hA5A5_5A5A);

    // Reset landing on the capture cycle of a WB read.
    @(negedge core_clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF; wb_adr_i = 32'h40;
    @(negedge core_clk);
    @(negedge core_clk);
    core_rst = 1;
    @(negedge core_clk);
    chk("abort_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("abort_wb_dat", wb_dat_o, 32'd0);
    chk("abort_hk_data", hk_ro_data, 32'd0);
    chk("abort_ena", {31'b0, mem_ena}, 32'd0);
    chk("abort_addr", {24'b0, mem_addr}, 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    core_rst = 0; wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge core_clk);
    chk("abort_no_late_ack", {31'b0, wb_ack_o}, 32'd0);
    wb_xfer(0, 32'h40, 4'hF, 32'h0, lat, ena, wen, ad, rd);
    chk("post_abort_lat", lat, 3);
    chk("post_abort_data", rd, 32'hDEADBEEF);

    // Simultaneous held requests alternate, HK first.
    @(negedge core_clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h40;
    hk_ro_req = 1; hk_ro_addr = 8'h11;
    nack = 0; nena = 0;
    for (int k = 0; k < 40 && nack < 4; k++) begin
      @(negedge core_clk);
      if (mem_ena) nena++;
      if (wb_ack_o && hk_ro_ack) chk("rr_dual_ack", 32'd1, 32'd0);
      if (hk_ro_ack) begin order[nack] = 1; nack++; end
      else if (wb_ack_o) begin order[nack] = 0; nack++; end
    end
    wb_cyc_i = 0; wb_stb_i = 0; hk_ro_req = 0;
    chk("rr_acks", nack, 4);
    chk("rr_ena_cycles", nena, 4);
    if (nack == 4) begin
      chk("rr_order0", order[0], 1);
      chk("rr_order1", order[1], 0);
      chk("rr_order2", order[2], 1);
      chk("rr_order3", order[3], 0);
    end

    wb_xfer(1, 32'h0, 4'h3, 32'h1111_2222, lat, ena, wen, ad, rd);
    chk("wp_lat", lat, 2);
    @(negedge core_clk);
`ifdef MGMT_SRAM_ARB_WPROT_EN
    chk("wp_wen", {28'b0, wen}, 32'h0);
    chk("wp_viol", {31'b0, wprot_viol}, 32'd1);
    wb_xfer(1, 32'h40, 4'hF, 32'hCAFE_F00D, lat, ena, wen, ad, rd);
    chk("wp_ok_wen", {28'b0, wen}, 32'hF);
    chk("wp_viol_held", {31'b0, wprot_viol}, 32'd1);
`else
    chk("nowp_wen", {28'b0, wen}, 32'h3);
    chk("nowp_viol", {31'b0, wprot_viol}, 32'd0);
`endif

    // Randomized traffic with occasional resets and abandoned WB cycles.
    wb_act = 0; hk_act = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge core_clk);
      if (core_rst) core_rst = 0;
      else if ($urandom_range(0, 299) == 0) core_rst = 1;
      if (wb_act) begin
        if (wb_ack_o || $urandom_range(0, 39) == 0) begin
          wb_act = 0; wb_cyc_i = 0; wb_stb_i = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        wb_act = 1; wb_cyc_i = 1; wb_stb_i = 1;
        wb_we_i = 1'($urandom_range(0, 1));
        wb_sel_i = 4'($urandom_range(0, 15));
        wb_dat_i = $urandom;
        v = $urandom;
        if ($urandom_range(0, 1) == 1) v[9:2] = 8'($urandom_range(0, 31));
        wb_adr_i = v;
      end
      if (hk_act) begin
        if (hk_ro_ack) begin hk_act = 0; hk_ro_req = 0; end
      end else if ($urandom_range(0, 2) == 0) begin
        hk_act = 1; hk_ro_req = 1;
        hk_ro_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      end
    end
    wb_cyc_i = 0; wb_stb_i = 0; hk_ro_req = 0; core_rst = 0;
    repeat (6) @(negedge core_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mgmt_sram_arbiter.md
Name: mgmt_sram_arbiter

Overview:
- Sequences and shares the single-port synchronous management SRAM (DFFRAM, 1-cycle read latency) between two requesters: the CPU Wishbone slave port (read/write, byte lanes) and the housekeeping read-only port (word reads).
- Sits between mgmt_core's bus fabric / housekeeping SRAM-RO path and the RAM macro's mem_ena / mem_wen / mem_addr / mem_wdata / mem_rdata pins.
- Single clock domain; round-robin arbitration; one access in flight at a time.

Parameters:
- AW, 8, RAM word-address width (256 x 32-bit words).
- DW, 32, data width; fixed at 32, SEL width DW/8.
- WPROT_TOP, 8'h10, first writable word index; used only with the optional feature.

Ports:
- core_clk  in  1  clock.
- core_rst  in  1  synchronous active-high reset.
- wb_cyc_i  in  1  Wishbone cycle; already address-decoded for this slave.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lanes.
- wb_adr_i  in  32  byte address; word index = wb_adr_i[AW+1:2].
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_dat_o  out  32  read data, valid with wb_ack_o.
- hk_ro_req  in  1  housekeeping read request; level, held until ack.
- hk_ro_addr  in  AW  housekeeping word address, stable while req is high.
- hk_ro_ack  out  1  single-cycle acknowledge.
- hk_ro_data  out  32  read data; updated only with ack, held afterwards.
- mem_ena  out  1  RAM enable.
- mem_wen  out  4  RAM byte write enables.
- mem_addr  out  AW  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after a read enable.
- wprot_viol  out  1  sticky write-protect violation flag.

Behaviour:
- All outputs are registered. On reset every output is 0, FSM = IDLE, rr_ptr = WB.
- Sync reset mid-transaction aborts it: no ack is issued and the RAM is not re-enabled.
- FSM states: IDLE, ACCESS, CAPTURE, ACK.
- IDLE: a WB request is wb_cyc_i & wb_stb_i; an HK request is hk_ro_req.
  - If only one requests, grant it.
  - If both request, grant the side rr_ptr does not point to.
  - On grant, at the same edge: load mem_addr, mem_wdata and mem_wen (= wb_sel_i on a WB write, else 0); set mem_ena=1; set rr_ptr = granted side; go to ACCESS.
- ACCESS, one cycle, RAM performs the access. Next edge: mem_ena=0, mem_wen=0.
  - Write: go to ACK.
  - Read: go to CAPTURE.
- CAPTURE: at the edge, register mem_rdata into wb_dat_o or hk_ro_data (granted side only); go to ACK.
- ACK: the granted side's ack is high for exactly this cycle; next state IDLE.
  - Requests are not sampled in ACK, so a master dropping stb/req after ack never causes a double access.
- Latency, request sampled at edge N:
  - Write: wb_ack_o high in cycle N+2.
  - Read: ack high in cycle N+3.
  - Next grant is possible at edge N+3 (write) or N+4 (read).
- A WB write with wb_sel_i=0 still runs through ACCESS (mem_wen=0 with mem_ena=1, a harmless read) and is acked at N+2.
- wb_dat_o holds its last read value during writes and HK accesses.
- wb_cyc_i dropped mid-access: the access completes and a one-cycle ack is still driven (master ignores it).
- HK is never granted writes; mem_wen is always 0 for HK grants.
- Address bits above AW+1 of wb_adr_i are ignored (aliasing is accepted).

Optional Feature:
- Macro MGMT_SRAM_ARB_WPROT_EN.
- Defined:
  - A WB write with word index < WPROT_TOP is granted and acked with normal timing, but mem_wen is forced to 0.
  - wprot_viol is set to 1 and stays set until core_rst.
- Undefined:
  - No write protection.
  - wprot_viol is tied 0; WPROT_TOP is unused.

Test Plan:
- Reset, then WB write adr=32'h40, sel=4'hF, dat=32'hDEADBEEF → mem_ena=1 and mem_wen=4'hF at addr 8'h10 for exactly one cycle; wb_ack_o pulses at N+2.
- WB read adr=32'h40 after that write → mem_rdata sampled the cycle after ACCESS; wb_dat_o=32'hDEADBEEF with wb_ack_o at N+3.
- HK req addr=8'h10 → hk_ro_ack one cycle at N+3 with hk_ro_data=32'hDEADBEEF; mem_wen stays 0 throughout.
- WB read and HK read asserted in the same cycle, held through 4 transactions → first grant is HK (rr_ptr=WB after reset), then WB, HK, WB; exactly one ack per transaction and never two mem_ena cycles per grant.
- Reset asserted during CAPTURE of a WB read → no wb_ack_o; all outputs 0 the next cycle; FSM IDLE; the following request is served normally.
- With MGMT_SRAM_ARB_WPROT_EN, WB write adr=32'h0, sel=4'h3 → ack at N+2, mem_wen stays 0, wprot_viol=1 and held; a write at adr=32'h40 afterwards drives mem_wen=4'hF normally.
